// File: rtl/world_tri_streamer.sv
// rtl/world_tri_streamer.sv - writable triangle-world store streamed to the rasteriser
//
// Holds up to MAX_TRIANGLES triangles (3 vertices x X/Y/Z, unsigned COORD_W each).
// On start it presents every stored triangle, in index order, over a valid/ready handshake.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   wr_en, wr_idx, wr_data, wr_err   scene write port (IDLE only), reject pulse
//   clear                            empty the scene (tri_count = 0, contents kept)
//   start, busy, done                stream control / status
//   tri_valid, tri_ready, tri_idx,
//   tri_last, tri_data               triangle stream to the rasteriser
//   tri_count                        number of valid triangles in the scene
module world_tri_streamer #(
    parameter int MAX_TRIANGLES = 16,
    parameter int COORD_W       = 16,
    parameter int LOAD_DEFAULT  = 1,
    localparam int IDX_W = $clog2(MAX_TRIANGLES),
    localparam int CNT_W = $clog2(MAX_TRIANGLES + 1),
    localparam int TRI_W = 9 * COORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TRI_W-1:0] wr_data,
    output logic             wr_err,
    input  logic             clear,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             tri_valid,
    input  logic             tri_ready,
    output logic [IDX_W-1:0] tri_idx,
    output logic             tri_last,
    output logic [TRI_W-1:0] tri_data,
    output logic [CNT_W-1:0] tri_count
);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t           state, state_n;
    logic [TRI_W-1:0] store [MAX_TRIANGLES];

    logic             idle, wr_ok, xfer;
    logic [CNT_W-1:0] cnt_clr, cnt_n;
    logic [IDX_W-1:0] idx_n;
    logic [TRI_W-1:0] data_n;
    logic             last_n;

    // Default scene: a tetrahedron built from four corner vertices.
    function automatic logic [TRI_W-1:0] default_tri(input int t);
        logic [COORD_W-1:0]   lo, hi;
        logic [3*COORD_W-1:0] va, vb, vc, vd;
        lo = COORD_W'(100);
        hi = COORD_W'(200);
        va = {lo, lo, lo};          // (100,100,100), packed {z,y,x}
        vb = {lo, lo, hi};          // (200,100,100)
        vc = {lo, hi, lo};          // (100,200,100)
        vd = {hi, lo, lo};          // (100,100,200)
        case (t)
            0:       return {vc, vb, va};
            1:       return {vd, vb, va};
            2:       return {vd, vc, va};
            3:       return {vd, vc, vb};
            default: return '0;
        endcase
    endfunction

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign tri_valid = (state == STREAM);

    always_comb begin
        idle    = (state == IDLE);
        xfer    = tri_valid && tri_ready;
        // One extra bit so MAX_TRIANGLES itself is representable in the range test.
        wr_ok   = wr_en && idle && ({1'b0, wr_idx} < (IDX_W+1)'(MAX_TRIANGLES));
        // Clear acts before a same-edge write, so the write can regrow the count.
        cnt_clr = (idle && clear) ? '0 : tri_count;
        cnt_n   = cnt_clr;
        if (wr_ok && (CNT_W'(wr_idx) >= cnt_clr)) begin
            cnt_n = CNT_W'(wr_idx) + 1'b1;
        end

        state_n = state;
        idx_n   = tri_idx;
        data_n  = tri_data;
        last_n  = tri_last;
        case (state)
            IDLE: begin
                if (start) begin
                    if (cnt_n != '0) begin
                        state_n = STREAM;
                        idx_n   = '0;
                        // Bypass a same-edge write into slot 0 so the stream sees it.
                        data_n  = (wr_ok && (wr_idx == '0)) ? wr_data : store[0];
                        last_n  = (cnt_n == CNT_W'(1));
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            STREAM: begin
                if (xfer) begin
                    if (tri_last) begin
                        state_n = DONE;
                    end else begin
                        // Look up the next slot now so it is presented without a bubble.
                        idx_n  = tri_idx + 1'b1;
                        data_n = store[idx_n];
                        last_n = ((CNT_W'(idx_n) + 1'b1) == tri_count);
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tri_idx   <= '0;
            tri_data  <= '0;
            tri_last  <= 1'b0;
            wr_err    <= 1'b0;
            tri_count <= (LOAD_DEFAULT != 0) ? CNT_W'(4) : '0;
        end else begin
            tri_idx   <= idx_n;
            tri_data  <= data_n;
            tri_last  <= last_n;
            wr_err    <= wr_en && !wr_ok;
            tri_count <= cnt_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_TRIANGLES; i++) begin
                store[i] <= ((LOAD_DEFAULT != 0) && (i < 4)) ? default_tri(i) : '0;
            end
        end else if (wr_ok) begin
            store[wr_idx] <= wr_data;
        end
    end

endmodule

// File: tb/tb_world_tri_streamer.sv
// tb/tb_world_tri_streamer.sv - directed self-checking bench for world_tri_streamer
module tb_world_tri_streamer;

    localparam int MAXT = 12;
    localparam int CW   = 16;
    localparam int IW   = 4;
    localparam int CNW  = 4;
    localparam int TW   = 9 * CW;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [TW-1:0] wr_data;
    logic          wr_err;
    logic          clear;
    logic          start;
    logic          busy;
    logic          done;
    logic          tri_valid;
    logic          tri_ready;
    logic [IW-1:0] tri_idx;
    logic          tri_last;
    logic [TW-1:0] tri_data;
    logic [CNW-1:0] tri_count;

    int checks;
    int errors;

    logic [TW-1:0] exp_store [MAXT];
    int            exp_count;

    world_tri_streamer #(
        .MAX_TRIANGLES(MAXT),
        .COORD_W      (CW),
        .LOAD_DEFAULT (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .wr_err   (wr_err),
        .clear    (clear),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .tri_valid(tri_valid),
        .tri_ready(tri_ready),
        .tri_idx  (tri_idx),
        .tri_last (tri_last),
        .tri_data (tri_data),
        .tri_count(tri_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [TW-1:0] mk(input int x0, input int y0, input int z0,
                                         input int x1, input int y1, input int z1,
                                         input int x2, input int y2, input int z2);
        logic [TW-1:0] t;
        t = '0;
        t[0*CW +: CW] = CW'(x0);
        t[1*CW +: CW] = CW'(y0);
        t[2*CW +: CW] = CW'(z0);
        t[3*CW +: CW] = CW'(x1);
        t[4*CW +: CW] = CW'(y1);
        t[5*CW +: CW] = CW'(z1);
        t[6*CW +: CW] = CW'(x2);
        t[7*CW +: CW] = CW'(y2);
        t[8*CW +: CW] = CW'(z2);
        return t;
    endfunction

    task automatic load_default();
        for (int i = 0; i < MAXT; i++) exp_store[i] = '0;
        exp_store[0] = mk(100,100,100, 200,100,100, 100,200,100);
        exp_store[1] = mk(100,100,100, 200,100,100, 100,100,200);
        exp_store[2] = mk(100,100,100, 100,200,100, 100,100,200);
        exp_store[3] = mk(200,100,100, 100,200,100, 100,100,200);
        exp_count = 4;
    endtask

    // Called at a negedge; pulses start and consumes the stream.
    // mode 0: tri_ready held high; mode 1: tri_ready pattern 1,0,0,1 repeating.
    task automatic run_stream(input int mode);
        int k;
        bit got;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        clear = 1'b0;
        k   = 0;
        got = 1'b0;
        for (int cyc = 0; cyc < 200 && !got; cyc++) begin
            tri_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (mode == 0) chk("no_bubble", tri_valid, k < exp_count);
            if (tri_valid) begin
                chk("idx", tri_idx, k);
                chk("data", tri_data, exp_store[k % MAXT]);
                chk("last", tri_last, k == exp_count - 1);
                chk("busy_stream", busy, 1);
                if (tri_ready) k++;
            end
            if (done) begin
                got = 1'b1;
                chk("end_count", k, exp_count);
                if (mode == 0) chk("done_cycle", cyc, exp_count);
            end else begin
                @(negedge clk);
            end
        end
        chk("stream_done", got, 1);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("back_idle", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = '0;
        wr_data   = '0;
        clear     = 1'b0;
        start     = 1'b0;
        tri_ready = 1'b0;
        load_default();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", tri_valid, 0);
        chk("rst_idx", tri_idx, 0);
        chk("rst_data", tri_data, 0);
        chk("rst_last", tri_last, 0);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_count", tri_count, 4);

        run_stream(0);
        run_stream(1);

        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_count = 0;
        chk("clear_count", tri_count, 0);
        run_stream(0);

        wr_en   = 1'b1;
        wr_idx  = 4'd5;
        wr_data = mk(7,7,7, 7,7,7, 7,7,7);
        @(negedge clk);
        wr_en = 1'b0;
        exp_store[5] = mk(7,7,7, 7,7,7, 7,7,7);
        exp_count = 6;
        chk("wr5_count", tri_count, 6);
        chk("wr5_no_err", wr_err, 0);
        run_stream(0);

        start     = 1'b1;
        tri_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("stall_valid", tri_valid, 1);
        wr_en   = 1'b1;
        wr_idx  = 4'd1;
        wr_data = {TW{1'b1}};
        @(negedge clk);
        wr_en = 1'b0;
        chk("busy_wr_err", wr_err, 1);
        chk("busy_wr_count", tri_count, 6);
        @(negedge clk);
        chk("wr_err_pulse", wr_err, 0);
        tri_ready = 1'b1;
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        chk("drain_done", done, 1);
        @(negedge clk);

        wr_en   = 1'b1;
        wr_idx  = 4'(MAXT);
        wr_data = {TW{1'b1}};
        @(negedge clk);
        wr_en = 1'b0;
        chk("range_wr_err", wr_err, 1);
        chk("range_count", tri_count, 6);
        run_stream(0);

        clear   = 1'b1;
        wr_en   = 1'b1;
        wr_idx  = 4'd2;
        wr_data = mk(1,2,3, 4,5,6, 7,8,9);
        @(negedge clk);
        clear = 1'b0;
        wr_en = 1'b0;
        exp_store[2] = mk(1,2,3, 4,5,6, 7,8,9);
        exp_count = 3;
        chk("clr_wr_count", tri_count, 3);
        run_stream(1);

        start     = 1'b1;
        tri_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_reset_idx", tri_idx, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", tri_valid, 0);
        chk("mid_rst_idx", tri_idx, 0);
        chk("mid_rst_data", tri_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_last", tri_last, 0);
        chk("mid_rst_count", tri_count, 4);
        @(negedge clk);
        rst_n = 1'b1;
        load_default();
        @(negedge clk);
        run_stream(0);

        wr_en   = 1'b1;
        wr_idx  = 4'd0;
        wr_data = mk(300,100,100, 200,100,100, 100,200,100);
        exp_store[0] = mk(300,100,100, 200,100,100, 100,200,100);
        run_stream(0);
        chk("same_edge_count", tri_count, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
